trig_sched: RTL

Shared delayed-trigger scheduler. Up to NCH requesters each raise a level `enable`. A rising edge on a channel clears that channel's `trigger` and queues it. One shared down-counter services the queued channels in round-robin order and sets each channel's `trigger` after a programmed number of clock edges. It replaces per-channel free-running edge-wait processes with one counter and one FSM, and sits between the stimulus/enable sources and the logic that consumes the triggers.

---
 rtl/trig_sched_pkg.sv | 28 ++
 rtl/trig_sched_if.sv | 35 +++
 rtl/trig_sched_rr_pick.sv | 35 +++
 rtl/trig_sched.sv | 133 +++++++++++++
 4 files changed

// File: rtl/trig_sched_pkg.sv
// Shared definitions for the delayed-trigger scheduler: FSM state encoding,
// parameter range limits and the grant/pointer index width helper.
package trig_sched_pkg;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_e;

  // Plain-vector state constants for the FSM register.
  localparam logic [0:0] ST_IDLE  = S_IDLE;
  localparam logic [0:0] ST_COUNT = S_COUNT;

  localparam int NCH_MIN = 2;
  localparam int NCH_MAX = 16;
  localparam int DW_MIN  = 1;
  localparam int DW_MAX  = 32;

  // Width of a channel index; never narrower than one bit.
  function automatic int idx_w(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/trig_sched_if.sv
// Request/trigger bundle between enable sources, the scheduler and the
// trigger consumers. The master drives enable/delay; the slave (scheduler)
// drives trigger/busy/grant.
interface trig_sched_if
  import trig_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW  = 8
) ();

  localparam int IW = idx_w(NCH);

  logic [NCH-1:0] enable;
  logic [DW-1:0]  delay;
  logic [NCH-1:0] trigger;
  logic           busy;
  logic [IW-1:0]  grant;

  modport master (
    output enable,
    output delay,
    input  trigger,
    input  busy,
    input  grant
  );

  modport slave (
    input  enable,
    input  delay,
    output trigger,
    output busy,
    output grant
  );

endinterface

// File: rtl/trig_sched_rr_pick.sv
// rr_pick: combinational round-robin picker. Returns the first set request
// bit scanning upward from ptr+1 with wrap-around, so the channel at ptr
// itself has the lowest priority.
module rr_pick
  import trig_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] sel
);

  // Rotating first-set scan starting just after the last grant.
  always_comb begin
    int   idx;
    logic found;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!found && req[idx]) begin
        sel   = IW'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    valid = found;
  end

endmodule

// File: rtl/trig_sched.sv
// trig_sched: shared delayed-trigger scheduler. Rising enables queue their
// channel; one down-counter services queued channels in round-robin order and
// raises each channel's trigger after the programmed number of edges.
// Optional build macro: TRIG_SCHED_CANCEL_EN (a falling enable withdraws the
// request and aborts an in-progress count for that channel).
module trig_sched
  import trig_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW  = 8
) (
  input  logic         clock,
  input  logic         reset,
  trig_sched_if.slave  bus
);

  localparam int             IW      = idx_w(NCH);
  localparam logic [IW-1:0]  PTR_RST = IW'(NCH - 1);
  localparam logic [DW-1:0]  CNT_ONE = DW'(1);

  logic [NCH-1:0] enable_q,  enable_d;
  logic [NCH-1:0] pending_q, pending_d;
  logic [NCH-1:0] trigger_q, trigger_d;
  logic [IW-1:0]  grant_q,   grant_d;
  logic [IW-1:0]  ptr_q,     ptr_d;
  logic [DW-1:0]  cnt_q,     cnt_d;
  logic [0:0]     state_q,   state_d;
  logic           busy_q,    busy_d;

  logic [NCH-1:0] rise_s;
  logic [NCH-1:0] cancel_mask_s;
  logic           cancel_s;
  logic           pick_valid_s;
  logic [IW-1:0]  pick_sel_s;
  logic [DW-1:0]  delay_eff_s;

  assign rise_s = bus.enable & ~enable_q;

`ifdef TRIG_SCHED_CANCEL_EN
  logic [NCH-1:0] fall_s;
  assign fall_s        = ~bus.enable & enable_q;
  assign cancel_mask_s = fall_s;
`else
  assign cancel_mask_s = '0;
`endif

  // A withdrawn request on the counting channel aborts the count.
  assign cancel_s = cancel_mask_s[grant_q];

  // A programmed delay of zero is serviced as one edge.
  assign delay_eff_s = (bus.delay == '0) ? CNT_ONE : bus.delay;

  rr_pick #(
    .N  (NCH),
    .IW (IW)
  ) u_pick (
    .req   (pending_q),
    .ptr   (ptr_q),
    .valid (pick_valid_s),
    .sel   (pick_sel_s)
  );

  // Next-state logic: FSM grant/count, then edge events layered on top so a
  // new rise always overrides a same-edge grant clear or completion set.
  always_comb begin
    enable_d  = bus.enable;
    pending_d = pending_q;
    trigger_d = trigger_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    state_d   = state_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          grant_d               = pick_sel_s;
          ptr_d                 = pick_sel_s;
          pending_d[pick_sel_s] = 1'b0;
          cnt_d                 = delay_eff_s;
          state_d               = ST_COUNT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (cancel_s) begin
          state_d = ST_IDLE;
        end else if (cnt_q <= CNT_ONE) begin
          trigger_d[grant_q] = 1'b1;
          state_d            = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    pending_d = (pending_d | rise_s) & ~cancel_mask_s;
    trigger_d = trigger_d & ~rise_s;
    busy_d    = (state_d == ST_COUNT);
  end

  // State registers with asynchronous reset; ptr resets so channel 0 wins first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enable_q  <= '0;
      pending_q <= '0;
      trigger_q <= '0;
      grant_q   <= '0;
      ptr_q     <= PTR_RST;
      cnt_q     <= '0;
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
    end else begin
      enable_q  <= enable_d;
      pending_q <= pending_d;
      trigger_q <= trigger_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.trigger = trigger_q;
  assign bus.busy    = busy_q;
  assign bus.grant   = grant_q;

endmodule
